// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_queue
//  Description : Write-side initiator for the 32x32 register file. Accepts
//                results from the memory and ALU stages over valid/ready,
//                keeps them in a DEPTH-entry in-order queue and drains one
//                entry per cycle onto the register-file write port. Also
//                answers pending-write / forwarding queries from decode.
//  Ports       :
//    clk, rst_n                       clock, asynchronous active-low reset
//    mem_valid/mem_ready/mem_rd/mem_data   memory-stage result handshake
//    alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//    wb_hold                          1 = do not drain this cycle
//    EnableWrite/write_reg/write_data register-file write port (head entry)
//    chk_reg/chk_pending/chk_data     forwarding query from decode
//    count                            number of occupied entries
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     wb_hold,
  output logic                     EnableWrite,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        chk_reg,
  output logic                     chk_pending,
  output logic [DATA_W-1:0]        chk_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  // Queue storage
  logic [ADDR_W-1:0]  r_rd_q   [DEPTH];
  logic [DATA_W-1:0]  r_data_q [DEPTH];

  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_mem_hs;
  logic               w_alu_hs;
  logic               w_mem_enq;
  logic               w_alu_enq;
  logic               w_pop;
  logic [c_CNT_W-1:0] w_alu_limit;
  logic [c_PTR_W-1:0] w_alu_wr_idx;

  // Readiness is derived from the registered count only; a pop in the same
  // cycle gives no extra credit, so a full queue refuses both producers.
  assign mem_ready    = (r_count <= c_CNT_W'(DEPTH - 1));
  assign w_mem_hs     = mem_valid & mem_ready;
  // When the memory result takes a slot this cycle, the ALU needs one more.
  assign w_alu_limit  = w_mem_hs ? c_CNT_W'(DEPTH - 2) : c_CNT_W'(DEPTH - 1);
  assign alu_ready    = (r_count <= w_alu_limit);
  assign w_alu_hs     = alu_valid & alu_ready;

  // Writes to r0 complete the handshake but are dropped.
  assign w_mem_enq    = w_mem_hs & (mem_rd != '0);
  assign w_alu_enq    = w_alu_hs & (alu_rd != '0);

  // Memory entry is older, so the ALU entry lands one slot behind it.
  assign w_alu_wr_idx = r_wr_ptr + c_PTR_W'(w_mem_enq);

  // Write port is driven straight from the head entry.
  assign w_pop        = (r_count != '0) & ~wb_hold;
  assign EnableWrite  = w_pop;
  assign write_reg    = (r_count != '0) ? r_rd_q[r_rd_ptr]   : '0;
  assign write_data   = (r_count != '0) ? r_data_q[r_rd_ptr] : '0;
  assign count        = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop);
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_mem_enq) + c_PTR_W'(w_alu_enq);
      r_count  <= r_count + c_CNT_W'(w_mem_enq) + c_CNT_W'(w_alu_enq)
                  - c_CNT_W'(w_pop);
    end
  end

  // Entry contents need no reset: they are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_mem_enq) begin
      r_rd_q[r_wr_ptr]   <= mem_rd;
      r_data_q[r_wr_ptr] <= mem_data;
    end
    if (w_alu_enq) begin
      r_rd_q[w_alu_wr_idx]   <= alu_rd;
      r_data_q[w_alu_wr_idx] <= alu_data;
    end
  end

  // Scan oldest to youngest; the last match wins so chk_data carries the
  // youngest queued value. The head stays visible even while it is popping,
  // since the file only takes the value at the same edge.
  always_comb begin
    chk_pending = 1'b0;
    chk_data    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((chk_reg != '0) && (c_CNT_W'(i) < r_count) &&
          (r_rd_q[r_rd_ptr + c_PTR_W'(i)] == chk_reg)) begin
        chk_pending = 1'b1;
        chk_data    = r_data_q[r_rd_ptr + c_PTR_W'(i)];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_queue
//  Description : Self-checking bench for regfile_wb_queue. A queue-based
//                reference model predicts every output each cycle; directed
//                scenarios are followed by a randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_valid, alu_valid, wb_hold;
  logic              mem_ready, alu_ready;
  logic [ADDR_W-1:0] mem_rd, alu_rd, chk_reg;
  logic [DATA_W-1:0] mem_data, alu_data;
  logic              EnableWrite, chk_pending;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data, chk_data;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t q[$];

  regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .wb_hold(wb_hold),
    .EnableWrite(EnableWrite), .write_reg(write_reg), .write_data(write_data),
    .chk_reg(chk_reg), .chk_pending(chk_pending), .chk_data(chk_data),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model predictions from the queue contents and current inputs.
  function automatic logic exp_mem_ready();
    return q.size() < DEPTH;
  endfunction

  function automatic logic exp_alu_ready();
    int taken = (mem_valid && exp_mem_ready()) ? 1 : 0;
    return (q.size() + taken) < DEPTH;
  endfunction

  task automatic check_model();
    logic              pend = 1'b0;
    logic [DATA_W-1:0] fwd  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!pend && chk_reg != 0 && q[i].rd == chk_reg) begin
        pend = 1'b1;
        fwd  = q[i].data;
      end
    end
    chk("mem_ready",   32'(mem_ready),   32'(exp_mem_ready()));
    chk("alu_ready",   32'(alu_ready),   32'(exp_alu_ready()));
    chk("EnableWrite", 32'(EnableWrite), 32'(q.size() != 0 && !wb_hold));
    chk("write_reg",   32'(write_reg),   (q.size() != 0) ? 32'(q[0].rd) : 32'd0);
    chk("write_data",  write_data,       (q.size() != 0) ? q[0].data    : 32'd0);
    chk("chk_pending", 32'(chk_pending), 32'(pend));
    chk("chk_data",    chk_data,         fwd);
    chk("count",       32'(count),       32'(q.size()));
  endtask

  // One clock: check settled outputs, then advance the model across the edge.
  task automatic cycle();
    logic pop, macc, aacc;
    ent_t e;
    #3;
    check_model();
    pop  = (q.size() != 0) && !wb_hold;
    macc = mem_valid && exp_mem_ready() && (mem_rd != 0);
    aacc = alu_valid && exp_alu_ready() && (alu_rd != 0);
    @(posedge clk);
    if (rst_n) begin
      if (pop) void'(q.pop_front());
      if (macc) begin e.rd = mem_rd; e.data = mem_data; q.push_back(e); end
      if (aacc) begin e.rd = alu_rd; e.data = alu_data; q.push_back(e); end
    end
    #1;
  endtask

  task automatic drive(input logic mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md,
                       input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input logic hold, input logic [ADDR_W-1:0] cr);
    mem_valid = mv; mem_rd = mr; mem_data = md;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    wb_hold = hold; chk_reg = cr;
  endtask

  task automatic idle(input logic hold);
    drive(1'b0, '0, '0, 1'b0, '0, '0, hold, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b0);
    @(posedge clk); #1;
    cycle();
    rst_n = 1'b1;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_en",    32'(EnableWrite), 32'd0);
    cycle();

    // 1: three entries held, then asynchronous reset mid-cycle
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, '0);
    cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 1'b1, '0);
    cycle();
    idle(1'b0);
    #1;
    chk("pre_reset_en", 32'(EnableWrite), 32'd1);
    chk("pre_reset_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_en",    32'(EnableWrite), 32'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    chk("post_reset_mem_ready", 32'(mem_ready), 32'd1);
    chk("post_reset_alu_ready", 32'(alu_ready), 32'd1);
    cycle();

    // 2: single ALU write, visible one edge later
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'd4, 1'b0, '0);
    cycle();
    idle(1'b0);
    #1;
    chk("single_en",   32'(EnableWrite), 32'd1);
    chk("single_reg",  32'(write_reg),   32'd9);
    chk("single_data", write_data,       32'd4);
    cycle();
    chk("single_drained", 32'(count), 32'd0);

    // 3: dual accept, memory entry drains first
    drive(1'b1, 5'd10, 32'd562, 1'b1, 5'd11, 32'd7, 1'b0, '0);
    cycle();
    idle(1'b0);
    #1;
    chk("dual_count2", 32'(count), 32'd2);
    chk("dual_first",  32'(write_reg), 32'd10);
    cycle();
    chk("dual_count1", 32'(count), 32'd1);
    chk("dual_second", 32'(write_reg), 32'd11);
    cycle();
    chk("dual_count0", 32'(count), 32'd0);

    // 4: fill under hold, refuse more, then drain
    drive(1'b1, 5'd12, 32'hA0, 1'b1, 5'd13, 32'hA1, 1'b1, '0);
    cycle();
    drive(1'b1, 5'd14, 32'hA2, 1'b1, 5'd15, 32'hA3, 1'b1, '0);
    cycle();
    drive(1'b1, 5'd16, 32'hA4, 1'b1, 5'd17, 32'hA5, 1'b1, '0);
    #1;
    chk("full_count",     32'(count), 32'd4);
    chk("full_mem_ready", 32'(mem_ready), 32'd0);
    chk("full_alu_ready", 32'(alu_ready), 32'd0);
    cycle();
    cycle();
    idle(1'b0);
    #1;
    chk("full_pop_mem_ready", 32'(mem_ready), 32'd0);
    chk("full_pop_reg",       32'(write_reg), 32'd12);
    for (int i = 0; i < 4; i++) cycle();
    chk("full_drained", 32'(count), 32'd0);

    // 5: forwarding picks the youngest match
    drive(1'b1, 5'd5, 32'd100, 1'b1, 5'd5, 32'd200, 1'b1, 5'd5);
    cycle();
    idle(1'b1);
    chk_reg = 5'd5;
    #1;
    chk("fwd_pending", 32'(chk_pending), 32'd1);
    chk("fwd_data",    chk_data, 32'd200);
    cycle();
    chk_reg = 5'd0;
    #1;
    chk("fwd_r0_pending", 32'(chk_pending), 32'd0);
    cycle();
    idle(1'b0);
    cycle();
    cycle();

    // 6: r0 write is accepted and dropped
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0);
    #1;
    chk("r0_ready", 32'(alu_ready), 32'd1);
    cycle();
    idle(1'b0);
    #1;
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_en",    32'(EnableWrite), 32'd0);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)));
      cycle();
    end

    idle(1'b0);
    for (int n = 0; n < DEPTH + 2; n++) cycle();
    chk("final_empty", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
